// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Serially loaded program store and fetch unit for the 3-bit
//               core. Streams (opcode, operand) word pairs to decode, follows
//               taken jumps from execute and halts when the instruction
//               pointer runs past the end of the loaded program.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
   parameter int PROG_DEPTH = 16,
   parameter int PC_W       = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_valid_i,
   input  logic [2:0]      load_data_i,
   input  logic            load_done_i,
   input  logic            start_i,
   input  logic            stall_i,
   input  logic            jump_taken_i,
   input  logic [2:0]      jump_target_i,
   output logic [2:0]      opcode_o,
   output logic [2:0]      operand_o,
   output logic            instr_valid_o,
   output logic            halt_o,
   output logic [PC_W:0]   pc_o,
   output logic            load_err_o
);

   // Store capacity and unit increment at pointer width (one extra bit so
   // that a full store, PROG_DEPTH, is representable).
   localparam logic [PC_W:0] C_DEPTH = (PC_W+1)'(PROG_DEPTH);
   localparam logic [PC_W:0] C_ONE   = (PC_W+1)'(1);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      mem_q [PROG_DEPTH];
   logic [PC_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PC_W:0]   len_q, len_d;
   logic [PC_W:0]   pc_q, pc_d;
   logic [2:0]      opcode_q, opcode_d;
   logic [2:0]      operand_q, operand_d;
   logic            valid_q, valid_d;
   logic            halt_q, halt_d;
   logic            load_err_q, load_err_d;

   logic            w_wr_room;
   logic            w_wr_en;
   logic [PC_W:0]   w_pc_inc1;
   logic            w_fetch_ok;
   logic [PC_W:0]   w_jump_pc;

   // Write acceptance, fetch-range test and zero-extended jump target.
   assign w_wr_room  = (wr_ptr_q != C_DEPTH);
   assign w_wr_en    = (state_q == ST_LOAD) && load_valid_i && w_wr_room;
   assign w_pc_inc1  = pc_q + C_ONE;
   assign w_fetch_ok = (w_pc_inc1 < len_q);
   assign w_jump_pc  = {{(PC_W-2){1'b0}}, jump_target_i};

   // Program store: written only while loading, contents survive execution.
   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         mem_q[wr_ptr_q[PC_W-1:0]] <= load_data_i;
      end
   end

   // State and output registers; reset returns to LOAD with everything cleared.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_LOAD;
         wr_ptr_q   <= '0;
         len_q      <= '0;
         pc_q       <= '0;
         opcode_q   <= '0;
         operand_q  <= '0;
         valid_q    <= 1'b0;
         halt_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         len_q      <= len_d;
         pc_q       <= pc_d;
         opcode_q   <= opcode_d;
         operand_q  <= operand_d;
         valid_q    <= valid_d;
         halt_q     <= halt_d;
         load_err_q <= load_err_d;
      end
   end

   // Next-state logic: loading, start handshake, fetch/jump/stall, halt.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      len_d      = len_q;
      pc_d       = pc_q;
      opcode_d   = opcode_q;
      operand_d  = operand_q;
      valid_d    = valid_q;
      halt_d     = halt_q;
      load_err_d = load_err_q;

      case (state_q)
         ST_LOAD: begin
            if (load_valid_i) begin
               if (w_wr_room) begin
                  wr_ptr_d = wr_ptr_q + C_ONE;
               end else begin
                  load_err_d = 1'b1;
               end
            end
            // Length includes a word written in the same cycle.
            if (load_done_i) begin
               len_d   = wr_ptr_d;
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (start_i) begin
               pc_d    = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A jump wins over a stall and always inserts one bubble.
            if (jump_taken_i) begin
               pc_d    = w_jump_pc;
               valid_d = 1'b0;
            end else if (!stall_i) begin
               if (w_fetch_ok) begin
                  opcode_d  = mem_q[pc_q[PC_W-1:0]];
                  operand_d = mem_q[w_pc_inc1[PC_W-1:0]];
                  valid_d   = 1'b1;
                  pc_d      = pc_q + C_ONE + C_ONE;
               end else begin
                  valid_d = 1'b0;
                  halt_d  = 1'b1;
                  state_d = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            if (start_i) begin
               halt_d  = 1'b0;
               pc_d    = '0;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   assign opcode_o      = opcode_q;
   assign operand_o     = operand_q;
   assign instr_valid_o = valid_q;
   assign halt_o        = halt_q;
   assign pc_o          = pc_q;
   assign load_err_o    = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed and randomized bench for instruction_fetch with a
//               behavioural program/fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_valid, load_done, start, stall, jump_taken;
   logic [2:0] load_data, jump_target;
   logic [2:0] opcode, operand;
   logic       instr_valid, halt, load_err;
   logic [4:0] pc;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: program as a list of words, plain integer pointers.
   int m_prog[$];
   int m_mode;          // 0 loading, 1 idle, 2 running, 3 halted
   int m_len, m_pc, m_op, m_opd, m_v, m_halt, m_err;

   int prog[$];

   always #5 clk = ~clk;

   instruction_fetch #(.PROG_DEPTH(16), .PC_W(4)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .load_valid_i  (load_valid),
      .load_data_i   (load_data),
      .load_done_i   (load_done),
      .start_i       (start),
      .stall_i       (stall),
      .jump_taken_i  (jump_taken),
      .jump_target_i (jump_target),
      .opcode_o      (opcode),
      .operand_o     (operand),
      .instr_valid_o (instr_valid),
      .halt_o        (halt),
      .pc_o          (pc),
      .load_err_o    (load_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".opcode"},   32'(opcode),      32'(m_op));
      chk({ctx, ".operand"},  32'(operand),     32'(m_opd));
      chk({ctx, ".valid"},    32'(instr_valid), 32'(m_v));
      chk({ctx, ".halt"},     32'(halt),        32'(m_halt));
      chk({ctx, ".pc"},       32'(pc),          32'(m_pc));
      chk({ctx, ".load_err"}, 32'(load_err),    32'(m_err));
   endtask

   task automatic model_reset();
      m_prog.delete();
      m_mode = 0; m_len = 0; m_pc = 0; m_op = 0; m_opd = 0;
      m_v = 0; m_halt = 0; m_err = 0;
   endtask

   task automatic model_step();
      case (m_mode)
         0: begin
            if (load_valid) begin
               if (m_prog.size() < 16) m_prog.push_back(int'(load_data));
               else m_err = 1;
            end
            if (load_done) begin
               m_len  = m_prog.size();
               m_mode = 1;
            end
         end
         1: if (start) begin m_pc = 0; m_mode = 2; end
         2: begin
            if (jump_taken) begin
               m_pc = int'(jump_target);
               m_v  = 0;
            end else if (!stall) begin
               if (m_pc + 1 < m_len) begin
                  m_op  = m_prog[m_pc];
                  m_opd = m_prog[m_pc + 1];
                  m_v   = 1;
                  m_pc  = m_pc + 2;
               end else begin
                  m_v = 0; m_halt = 1; m_mode = 3;
               end
            end
         end
         default: if (start) begin m_halt = 0; m_pc = 0; m_mode = 2; end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all("cyc");
   endtask

   task automatic quiet();
      load_valid = 0; load_done = 0; load_data = 0; start = 0;
      stall = 0; jump_taken = 0; jump_target = 0;
   endtask

   // Asynchronous reset asserted mid-cycle, checked before any clock edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      #1 rst_n = 1'b1;
   endtask

   task automatic load_prog(input bit done_with_last);
      foreach (prog[i]) begin
         load_valid = 1;
         load_data  = 3'(prog[i]);
         load_done  = done_with_last && (i == prog.size() - 1);
         tick();
      end
      quiet();
   endtask

   task automatic start_run();
      start = 1; tick(); start = 0;
   endtask

   task automatic run_until_halt(input int budget);
      for (int i = 0; i < budget && halt !== 1'b1; i++) tick();
      chk("halt_reached", 32'(halt), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      quiet();
      #3;
      model_reset();
      check_all("por");
      chk("por_pc", 32'(pc), 32'd0);
      #1 rst_n = 1'b1;

      // Four-word program, load_done alongside the final word.
      prog = {2, 4, 1, 3};
      load_prog(1);
      start_run();
      chk("a_bubble_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("a_i0_op", 32'(opcode), 32'd2);
      chk("a_i0_opd", 32'(operand), 32'd4);
      chk("a_i0_pc", 32'(pc), 32'd2);
      tick();
      chk("a_i1_op", 32'(opcode), 32'd1);
      chk("a_i1_opd", 32'(operand), 32'd3);
      tick();
      chk("a_halt", 32'(halt), 32'd1);
      chk("a_halt_valid", 32'(instr_valid), 32'd0);
      chk("a_halt_pc", 32'(pc), 32'd4);

      // Re-run from HALT, then reset while an instruction is valid.
      start_run();
      tick();
      chk("pre_reset_valid", 32'(instr_valid), 32'd1);
      do_reset();
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_opcode", 32'(opcode), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);

      // Six-word program: stall, jump, stall+jump, out-of-range jump.
      prog = {0, 3, 5, 4, 3, 0};
      load_prog(0);
      load_done = 1; tick(); load_done = 0;
      start_run();
      tick();
      chk("b_i0_op", 32'(opcode), 32'd0);
      chk("b_i0_opd", 32'(operand), 32'd3);
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("b_stall_op", 32'(opcode), 32'd5);
         chk("b_stall_pc", 32'(pc), 32'd4);
         chk("b_stall_valid", 32'(instr_valid), 32'd1);
      end
      stall = 0;
      tick();
      chk("b_i2_opd", 32'(operand), 32'd0);
      chk("b_i2_pc", 32'(pc), 32'd6);
      jump_taken = 1; jump_target = 0;
      tick();
      jump_taken = 0;
      chk("b_jump_bubble", 32'(instr_valid), 32'd0);
      chk("b_jump_pc", 32'(pc), 32'd0);
      tick();
      chk("b_target_op", 32'(opcode), 32'd0);
      chk("b_target_pc", 32'(pc), 32'd2);
      stall = 1; jump_taken = 1; jump_target = 2;
      tick();
      stall = 0; jump_taken = 0;
      chk("b_stalljump_pc", 32'(pc), 32'd2);
      chk("b_stalljump_valid", 32'(instr_valid), 32'd0);
      run_until_halt(10);
      start_run();
      jump_taken = 1; jump_target = 7;
      tick();
      jump_taken = 0;
      chk("b_jump7_pc", 32'(pc), 32'd7);
      tick();
      chk("b_jump7_halt", 32'(halt), 32'd1);

      // Odd length: trailing word never fetched; start from HALT re-runs.
      do_reset();
      prog = {1, 2, 7};
      load_prog(1);
      start_run();
      tick();
      chk("c_op", 32'(opcode), 32'd1);
      chk("c_opd", 32'(operand), 32'd2);
      tick();
      chk("c_halt", 32'(halt), 32'd1);
      chk("c_halt_pc", 32'(pc), 32'd2);
      start_run();
      chk("c_restart_halt", 32'(halt), 32'd0);
      tick();
      chk("c_rerun_valid", 32'(instr_valid), 32'd1);

      // Empty program halts one cycle after entering RUN.
      do_reset();
      load_done = 1; tick(); load_done = 0;
      start_run();
      tick();
      chk("d_halt", 32'(halt), 32'd1);
      chk("d_valid", 32'(instr_valid), 32'd0);

      // Overfill: 17 words into a 16-word store.
      do_reset();
      prog.delete();
      for (int i = 0; i < 17; i++) prog.push_back((i * 3 + 1) % 8);
      load_prog(1);
      chk("e_load_err", 32'(load_err), 32'd1);
      start_run();
      run_until_halt(20);
      chk("e_halt_pc", 32'(pc), 32'd16);

      // Randomized traffic on every input, checked against the model.
      for (int r = 0; r < 5; r++) begin
         do_reset();
         for (int c = 0; c < 200; c++) begin
            load_valid  = ($urandom_range(0, 1) == 1);
            load_data   = 3'($urandom_range(0, 7));
            load_done   = ($urandom_range(0, 24) == 0);
            start       = ($urandom_range(0, 7) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            jump_taken  = ($urandom_range(0, 5) == 0);
            jump_target = 3'($urandom_range(0, 7));
            tick();
         end
         quiet();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Program store and fetch unit for the 3-bit core. It is loaded serially with 3-bit program words, then streams (opcode, operand) pairs to instruction decode, one pair per unstalled cycle. It redirects on taken jumps from execute and raises `halt` when the instruction pointer runs past the end of the program. It is the producer feeding the decode stage's `opcode`/`operand`/`halt` inputs.

## Interface
- `PROG_DEPTH`, default 16: number of 3-bit program words stored; power of two, at least 8.
- `PC_W`, default 4: log2(`PROG_DEPTH`). The `pc` port and the program length are `PC_W+1` bits wide so the value `PROG_DEPTH` is representable.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  program word strobe; honoured only in LOAD.
- `load_data`  in  3  program word.
- `load_done`  in  1  ends loading; honoured only in LOAD.
- `start`  in  1  begin (or re-run) execution from word 0; honoured in IDLE and HALT.
- `stall`  in  1  hold fetch state and outputs.
- `jump_taken`  in  1  redirect request from execute.
- `jump_target`  in  3  literal jump target; a word address, zero-extended.
- `opcode`  out  3  fetched opcode, mem[pc].
- `operand`  out  3  fetched operand, mem[pc+1].
- `instr_valid`  out  1  `opcode`/`operand` hold a new instruction this cycle.
- `halt`  out  1  program finished; held high until `start` or reset.
- `pc`  out  PC_W+1  word address of the next fetch.
- `load_err`  out  1  sticky flag: a write was attempted into a full store.

## Operation
- Storage: `PROG_DEPTH` x 3-bit register array. Write pointer `wr_ptr` and length `len` are both `PC_W+1` bits.
- States: LOAD (reset state), IDLE, RUN, HALT.
- LOAD:
  - `load_valid` writes mem[wr_ptr] and increments `wr_ptr`.
  - If `wr_ptr == PROG_DEPTH`, the word is dropped and `load_err` is set.
  - `load_done` sets `len = wr_ptr` (counting a same-cycle `load_valid` word) and moves to IDLE.
- IDLE: `start` sets `pc = 0` and moves to RUN.
- RUN, each cycle with `stall = 0`:
  - Priority 1, `jump_taken`: `pc <= jump_target`, `instr_valid <= 0` (one bubble), `opcode`/`operand` hold their values.
  - Priority 2, `pc + 1 < len`: `opcode <= mem[pc]`, `operand <= mem[pc+1]`, `instr_valid <= 1`, `pc <= pc + 2`.
  - Otherwise: `instr_valid <= 0`, `halt <= 1`, go to HALT. `pc` keeps its value. This covers an odd trailing word and `len = 0`.
  - Comparisons use `PC_W+1` bits; no wrap-around. Memory reads at or beyond `len` are never registered.
- RUN with `stall = 1`:
  - A simultaneous `jump_taken` is still applied (`pc` updated, `instr_valid <= 0`); jump has priority over stall.
  - Otherwise `pc`, `opcode`, `operand` and `instr_valid` all hold.
- Squashing wrong-path instructions already downstream is the core's responsibility.
- HALT:
  - `jump_taken`, `stall`, `load_*` are ignored.
  - `start` clears `halt`, sets `pc = 0` and moves to RUN. Memory and `len` are retained.
- `start` in LOAD or RUN is ignored. `load_valid`/`load_done` outside LOAD are ignored. A new program requires reset.
- Reset (asynchronous, any state, including mid-run): state LOAD; `wr_ptr`, `len`, `pc` = 0; `opcode`, `operand` = 0; `instr_valid`, `halt`, `load_err` = 0. Memory contents are don't-care.

## Timing
- `start` sampled at edge E0 → RUN after E0. The first fetch is registered at E1, so `instr_valid` is high after E1.
- Fetch latency: 1 cycle. Throughput: 1 instruction per unstalled cycle.
- `jump_taken` sampled at edge E → `instr_valid = 0` after E → target instruction valid after E+1 (if in range).
- The end condition evaluated at edge E → `halt = 1` and `instr_valid = 0` after E.
- `load_done` sampled at E → IDLE after E; `start` is accepted from E+1.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Reset mid-RUN while `instr_valid = 1` → all outputs 0 immediately (asynchronously); state LOAD; a reload of new words works.
- Load 2,4,1,3 + `load_done`, then `start` → next two cycles (2,4) then (1,3) with `instr_valid = 1`; following cycle `halt = 1`, `instr_valid = 0`, `pc = 4`.
- Load 0,3,5,4,3,0; run; with `pc = 6` assert `jump_taken`, `jump_target = 0` → one cycle `instr_valid = 0`, `pc = 0`; next cycle (0,3) valid, `pc = 2`.
- Same program; hold `stall` 3 cycles after (5,4) → outputs frozen at (5,4), `instr_valid = 1`, `pc = 4`; on release (3,0) follows. `stall` together with `jump_taken`, target 2 → `pc = 2` and a bubble.
- Odd length, load 1,2,7 → a single (1,2) instruction, then `halt`, `pc = 2`. `len = 0` + `start` → `halt` one cycle after entering RUN with no valid instruction. `start` in HALT re-runs from 0.
- Write 17 words with `PROG_DEPTH = 16` → `load_err = 1`, `len = 16`, 17th word discarded; a jump to 7 in a 6-word program → `halt`.
